divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 142 ++++++++++++++
 tb/tb_divider_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: 2*DATA_W-bit dividend by DATA_W-bit divisor,
// one quotient bit per clock, with valid/ready handshakes on both sides.
module divider_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   N,
  input  logic [DATA_W-1:0]     D,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     Q,
  output logic [DATA_W-1:0]     R,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int REM_W = DATA_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [DATA_W-1:0]   r_q, r_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;

  logic [REM_W-1:0]    t;
  logic                t_ge_d;
  logic [REM_W-1:0]    step_rem;
  logic [DATA_W-1:0]   step_shift;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    // The remainder stays below D, so its top bit is always zero before the shift.
    t          = REM_W'({rem_q, shift_q[DATA_W-1]});
    t_ge_d     = (t >= {1'b0, d_q});
    step_rem   = t_ge_d ? (t - {1'b0, d_q}) : t;
    step_shift = {shift_q[DATA_W-2:0], t_ge_d};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          d_d = D;
          if (D == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = N[DATA_W-1:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
          end else if (N[2*DATA_W-1:DATA_W] >= D) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = N[DATA_W-1:0];
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            rem_d   = {1'b0, N[2*DATA_W-1:DATA_W]};
            shift_d = N[DATA_W-1:0];
            cnt_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end

      S_CALC: begin
        rem_d   = step_rem;
        shift_d = step_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_DONE;
          q_d     = step_shift;
          r_d     = step_rem[DATA_W-1:0];
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shift_q <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomized checks of divider_seq at DATA_W = 8: results,
// error flags, latency, backpressure, back-to-back accepts and mid-op reset.
module tb_divider_seq;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] N;
  logic [W-1:0]  D;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Q;
  logic [W-1:0]  R;
  logic          dbz;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  divider_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (N),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Caller is just after a negedge; returns just after the negedge following the accept edge.
  task automatic start_op(input logic [15:0] n, input logic [7:0] d);
    in_valid = 1'b1;
    N        = n;
    D        = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    N        = ~n;
    D        = ~d;
  endtask

  // Counts edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    N         = '0;
    D         = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    checks++;
    if ({Q, R, dbz, ovf} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got Q=%h R=%h dbz=%b ovf=%b, want all zero", Q, R, dbz, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    int cyc;
    start_op(16'd1000, 8'd7);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got in_ready=%b, want 0", in_ready);
    end
    wait_result(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, want 8", cyc);
    end
    checks++;
    if (Q !== 8'd142 || R !== 8'd6 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got Q=%0d R=%0d dbz=%b ovf=%b, want Q=142 R=6 dbz=0 ovf=0", Q, R, dbz, ovf);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    vec_t vecs[8] = '{
      '{16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 8},
      '{16'h0700,  8'd7,   8'hFF,  8'h00,  1'b0, 1'b1, 0},
      '{16'h1234,  8'd0,   8'hFF,  8'h34,  1'b1, 1'b0, 0},
      '{16'd0,     8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 8},
      '{16'd255,   8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8},
      '{16'h0100,  8'd1,   8'hFF,  8'h00,  1'b0, 1'b1, 0},
      '{16'hFFFF,  8'd0,   8'hFF,  8'hFF,  1'b1, 1'b0, 0},
      '{16'h7FFF,  8'd128, 8'd255, 8'd127, 1'b0, 1'b0, 8}
    };
    int cyc;
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].n, vecs[i].d);
      wait_result(cyc);
      checks++;
      if (cyc !== vecs[i].lat) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d edges, want %0d", i, cyc, vecs[i].lat);
      end
      checks++;
      if ({Q, R, dbz, ovf} !== {vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf}) begin
        errors++;
        $display("FAIL vec%0d_result: N=%h D=%h got Q=%h R=%h dbz=%b ovf=%b, want Q=%h R=%h dbz=%b ovf=%b",
                 i, vecs[i].n, vecs[i].d, Q, R, dbz, ovf, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    start_op(16'd1000, 8'd7);
    wait_result(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL bp_latency: got %0d edges, want 8", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== 8'd142 || R !== 8'd6 || dbz !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b Q=%0d R=%0d dbz=%b ovf=%b, want 1 0 142 6 0 0",
                 i, out_valid, in_ready, Q, R, dbz, ovf);
      end
      in_valid = 1'b1;
      N        = 16'h0700;
      D        = 8'd7;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Q !== 8'd142 || R !== 8'd6 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_pulses: got out_valid=%b Q=%0d R=%0d ovf=%b, want 1 142 6 0", out_valid, Q, R, ovf);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    out_ready = 1'b1;
    start_op(16'd1000, 8'd7);
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Q !== 8'd142 || R !== 8'd6) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d Q=%0d R=%0d, want 8 142 6", cyc, Q, R);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    start_op(16'd100, 8'd9);
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Q !== 8'd11 || R !== 8'd1) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d Q=%0d R=%0d, want 8 11 1", cyc, Q, R);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_op(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {Q, R, dbz, ovf} !== 18'h0) begin
      errors++;
      $display("FAIL midrst_async: got in_ready=%b out_valid=%b Q=%h R=%h dbz=%b ovf=%b, want 1 0 and zeros",
               in_ready, out_valid, Q, R, dbz, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_no_result%0d: got out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
      end
      @(negedge clk);
    end
    start_op(16'd100, 8'd9);
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Q !== 8'd11 || R !== 8'd1 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: got lat=%0d Q=%0d R=%0d dbz=%b ovf=%b, want 8 11 1 0 0", cyc, Q, R, dbz, ovf);
    end
    release_result();
  endtask

  task automatic test_random;
    int unsigned d_i, hi_i, n_i;
    logic [7:0]  q_e, r_e;
    logic        dbz_e, ovf_e;
    int          lat_e, cyc;
    for (int i = 0; i < 3000; i++) begin
      d_i = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) d_i = 0;
      if (d_i != 0 && $urandom_range(0, 3) != 0) hi_i = $urandom_range(0, d_i - 1);
      else hi_i = $urandom_range(0, 255);
      n_i = (hi_i << 8) | $urandom_range(0, 255);
      if (d_i == 0) begin
        q_e = 8'hFF; r_e = n_i[7:0]; dbz_e = 1'b1; ovf_e = 1'b0; lat_e = 0;
      end else if (hi_i >= d_i) begin
        q_e = 8'hFF; r_e = n_i[7:0]; dbz_e = 1'b0; ovf_e = 1'b1; lat_e = 0;
      end else begin
        q_e = 8'(n_i / d_i); r_e = 8'(n_i % d_i); dbz_e = 1'b0; ovf_e = 1'b0; lat_e = 8;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(n_i[15:0], d_i[7:0]);
      wait_result(cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (cyc !== lat_e || {Q, R, dbz, ovf} !== {q_e, r_e, dbz_e, ovf_e}) begin
        errors++;
        $display("FAIL rand%0d: N=%h D=%h got lat=%0d Q=%h R=%h dbz=%b ovf=%b, want lat=%0d Q=%h R=%h dbz=%b ovf=%b",
                 i, n_i[15:0], d_i[7:0], cyc, Q, R, dbz, ovf, lat_e, q_e, r_e, dbz_e, ovf_e);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
